// File: rtl/p2m_pkg.sv
// Shared widths, message layout and tag decode helper for the pipe-to-method demux.
package p2m_pkg;

    // Default geometry; module parameters may override these per instance.
    localparam int DEF_TAG_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_NUM_METHODS = 4;
    localparam int DEF_FIFO_DEPTH  = 2;

    // Width at which tags are compared against the method count.
    localparam int TAG_CMP_W = 64;

    // Channel-select width; a single method still needs one select bit.
    function automatic int ch_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Pointer width: one extra wrap bit tells full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CH_W  = ch_width(DEF_NUM_METHODS);
    localparam int PTR_W = ptr_width(DEF_FIFO_DEPTH);

    // Enq message layout: tag in the MSBs, payload in the LSBs.
    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] payload;
    } p2m_msg_t;

    // A tag addresses a real method only when it is below the method count.
    function automatic logic tag_valid(input logic [TAG_CMP_W-1:0] tag,
                                       input logic [TAG_CMP_W-1:0] num_methods);
        return (tag < num_methods);
    endfunction

endpackage

// File: rtl/p2m_chan_fifo.sv
// Per-method channel FIFO: power-of-two depth, wrap-bit pointers, zeroed output when empty.
module p2m_chan_fifo
    import p2m_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PW    = ptr_width(FIFO_DEPTH);

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push_s;
    logic                  do_pop_s;

    // Full when the wrap bits differ but the index bits match; empty when equal.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A full FIFO never accepts a push, even if it pops in the same cycle.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer next-state: advance only on an accepted operation, wrapping modulo 2*depth.
    always_comb begin
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; asynchronous reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
        end
    end

    // Head entry, forced to zero when nothing is queued.
    always_comb begin
        if (empty) begin
            dout = {DATA_WIDTH{1'b0}};
        end else begin
            dout = mem_q[rd_ptr_q[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/p2m_demux.sv
// Pipe-to-method demultiplexer: decodes the enq tag, steers payloads into
// per-method FIFOs, drops and counts out-of-range tags.
module p2m_demux
    import p2m_pkg::*;
#(
    parameter int TAG_WIDTH   = 16,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_METHODS = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0]   pipe_enq_v,
    input  logic                              pipe_enq_ena,
    output logic                              pipe_enq_rdy,
    output logic [NUM_METHODS*DATA_WIDTH-1:0] method_v,
    output logic [NUM_METHODS-1:0]            method_ena,
    input  logic [NUM_METHODS-1:0]            method_rdy,
    output logic [CNT_WIDTH-1:0]              drop_count,
    output logic [TAG_WIDTH-1:0]              last_bad_tag,
    input  logic                              clear_stats
);

    localparam int SEL_W = ch_width(NUM_METHODS);

    logic [TAG_WIDTH-1:0]  tag_s;
    logic [DATA_WIDTH-1:0] payload_s;
    logic                  valid_s;
    logic [SEL_W-1:0]      ch_s;
    logic                  sel_full_s;
    logic                  rdy_s;
    logic [NUM_METHODS-1:0] push_s;
    logic [NUM_METHODS-1:0] pop_s;
    logic [NUM_METHODS-1:0] full_s;
    logic [NUM_METHODS-1:0] empty_s;
    logic [DATA_WIDTH-1:0]  dout_s [NUM_METHODS];

    logic [CNT_WIDTH-1:0] drop_q;
    logic [CNT_WIDTH-1:0] drop_d;
    logic [TAG_WIDTH-1:0] bad_tag_q;
    logic [TAG_WIDTH-1:0] bad_tag_d;

    // Message split and tag decode, purely from the enq data bus.
    assign tag_s     = pipe_enq_v[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign payload_s = pipe_enq_v[DATA_WIDTH-1:0];
    assign valid_s   = tag_valid(TAG_CMP_W'(tag_s), TAG_CMP_W'(NUM_METHODS));
    assign ch_s      = tag_s[SEL_W-1:0];

    // Ready looks only at the addressed FIFO's full flag, never at method_rdy,
    // so there is no ready-to-ready combinational path. Bad tags are always taken.
    always_comb begin
        sel_full_s = 1'b0;
        for (int i = 0; i < NUM_METHODS; i++) begin
            sel_full_s = sel_full_s | (full_s[i] & (ch_s == SEL_W'(i)));
        end
        if (valid_s) begin
            rdy_s = ~sel_full_s;
        end else begin
            rdy_s = 1'b1;
        end
    end

    assign pipe_enq_rdy = rdy_s;

    // Push steering: only the addressed channel, only for a valid tag.
    always_comb begin
        push_s = {NUM_METHODS{1'b0}};
        for (int i = 0; i < NUM_METHODS; i++) begin
            if (pipe_enq_ena && valid_s && (ch_s == SEL_W'(i))) begin
                push_s[i] = ~full_s[i];
            end else begin
                push_s[i] = 1'b0;
            end
        end
    end

    // A method call fires whenever its FIFO has data and the client is ready.
    assign pop_s      = ~empty_s & method_rdy;
    assign method_ena = pop_s;

    for (genvar g = 0; g < NUM_METHODS; g++) begin : g_chan
        p2m_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (push_s[g]),
            .din   (payload_s),
            .full  (full_s[g]),
            .pop   (pop_s[g]),
            .dout  (dout_s[g]),
            .empty (empty_s[g])
        );
        assign method_v[g*DATA_WIDTH +: DATA_WIDTH] = dout_s[g];
    end

    // Drop statistics next-state: clear wins over a same-cycle drop; count saturates.
    always_comb begin
        drop_d    = drop_q;
        bad_tag_d = bad_tag_q;
        if (clear_stats) begin
            drop_d    = {CNT_WIDTH{1'b0}};
            bad_tag_d = {TAG_WIDTH{1'b0}};
        end else if (pipe_enq_ena && !valid_s) begin
            if (drop_q != {CNT_WIDTH{1'b1}}) begin
                drop_d = drop_q + CNT_WIDTH'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            bad_tag_d = tag_s;
        end else begin
            drop_d    = drop_q;
            bad_tag_d = bad_tag_q;
        end
    end

    // Drop statistics registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            drop_q    <= {CNT_WIDTH{1'b0}};
            bad_tag_q <= {TAG_WIDTH{1'b0}};
        end else begin
            drop_q    <= drop_d;
            bad_tag_q <= bad_tag_d;
        end
    end

    assign drop_count   = drop_q;
    assign last_bad_tag = bad_tag_q;

endmodule

// File: tb/tb_p2m_demux.sv
// Directed bench for p2m_demux with a queue-based reference model.
module tb_p2m_demux;
    import p2m_pkg::*;

    localparam int TW = 16;
    localparam int DW = 128;
    localparam int NM = 4;
    localparam int CW = 4;

    logic              CLK;
    logic              nRST;
    logic [TW+DW-1:0]  pipe_enq_v;
    logic              pipe_enq_ena;
    logic              pipe_enq_rdy;
    logic [NM*DW-1:0]  method_v;
    logic [NM-1:0]     method_ena;
    logic [NM-1:0]     method_rdy;
    logic [CW-1:0]     drop_count;
    logic [TW-1:0]     last_bad_tag;
    logic              clear_stats;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] mq [NM][$];
    int            m_drop = 0;
    logic [TW-1:0] m_bad  = '0;

    p2m_demux #(
        .TAG_WIDTH   (TW),
        .DATA_WIDTH  (DW),
        .NUM_METHODS (NM),
        .FIFO_DEPTH  (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pipe_enq_v   (pipe_enq_v),
        .pipe_enq_ena (pipe_enq_ena),
        .pipe_enq_rdy (pipe_enq_rdy),
        .method_v     (method_v),
        .method_ena   (method_ena),
        .method_rdy   (method_rdy),
        .drop_count   (drop_count),
        .last_bad_tag (last_bad_tag),
        .clear_stats  (clear_stats)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_msg(input logic [TW-1:0] t, input logic [DW-1:0] p);
        p2m_msg_t m;
        m.tag     = t;
        m.payload = p;
        pipe_enq_v = m;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model advance on each clock edge: pops from pre-edge state, then push, then stats.
    task automatic model_tick();
        logic [TW-1:0] t;
        int            pre [NM];
        t = pipe_enq_v[TW+DW-1:DW];
        for (int i = 0; i < NM; i++) pre[i] = mq[i].size();
        for (int i = 0; i < NM; i++) begin
            if (pre[i] > 0 && method_rdy[i]) void'(mq[i].pop_front());
        end
        if (pipe_enq_ena && t < NM && pre[t] < 2) mq[t].push_back(pipe_enq_v[DW-1:0]);
        if (clear_stats) begin
            m_drop = 0;
            m_bad  = '0;
        end else if (pipe_enq_ena && t >= NM) begin
            if (m_drop < 15) m_drop = m_drop + 1;
            m_bad = t;
        end
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NM; i++) mq[i].delete();
            m_drop = 0;
            m_bad  = '0;
        end else begin
            model_tick();
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    task automatic compare_tick();
        logic [TW-1:0] t;
        logic          er;
        t  = pipe_enq_v[TW+DW-1:DW];
        er = (t < NM) ? (mq[t].size() < 2) : 1'b1;
        check("m_rdy", pipe_enq_rdy, er);
        for (int i = 0; i < NM; i++) begin
            check($sformatf("m_ena%0d", i), method_ena[i], (mq[i].size() > 0) && method_rdy[i]);
            check($sformatf("m_v%0d", i), method_v[i*DW +: DW],
                  (mq[i].size() > 0) ? mq[i][0] : '0);
        end
        check("m_drop", drop_count, m_drop);
        check("m_bad", last_bad_tag, m_bad);
    endtask

    always @(negedge CLK) begin
        if (nRST && chk_en) compare_tick();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [TW-1:0] t3_tags [4];
    logic [DW-1:0] t3_pls  [4];

    initial begin
        nRST = 1'b0; pipe_enq_v = '0; pipe_enq_ena = 1'b0;
        method_rdy = 4'hF; clear_stats = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ena", method_ena, 4'b0000);
        check("rst_v", |method_v, 1'b0);
        check("rst_drop", drop_count, 4'h0);
        check("rst_bad", last_bad_tag, 16'h0000);
        check("rst_rdy", pipe_enq_rdy, 1'b1);
        nRST = 1'b1;
        step();
        chk_en = 1'b1;

        // Single message, one-cycle latency
        set_msg(16'd0, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF);
        pipe_enq_ena = 1'b1;
        #1;
        check("t1_no_bypass", method_ena, 4'b0000);
        step();
        pipe_enq_ena = 1'b0;
        check("t1_ena", method_ena, 4'b0001);
        check("t1_v0", method_v[127:0], 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF);
        step();
        check("t1_drained", method_ena, 4'b0000);

        // Stalled channel 2 fills, then blocks the third message
        method_rdy = 4'b1011;
        for (int k = 1; k <= 2; k++) begin
            set_msg(16'd2, DW'(k));
            pipe_enq_ena = 1'b1;
            step();
        end
        pipe_enq_ena = 1'b0;
        set_msg(16'd2, 128'd3);
        #1;
        check("t2_full_rdy", pipe_enq_rdy, 1'b0);
        check("t2_stall_ena", method_ena, 4'b0000);
        method_rdy = 4'hF;
        #1;
        check("t2_no_rdy_path", pipe_enq_rdy, 1'b0);
        check("t2_pop_ena", method_ena, 4'b0100);
        check("t2_head1", method_v[383:256], 128'd1);
        step();
        check("t2_rdy_back", pipe_enq_rdy, 1'b1);
        check("t2_head2", method_v[383:256], 128'd2);
        pipe_enq_ena = 1'b1;
        step();
        pipe_enq_ena = 1'b0;
        check("t2_head3", method_v[383:256], 128'd3);
        repeat (2) step();

        // Interleaved tags, full throughput
        t3_tags = '{16'd0, 16'd1, 16'd3, 16'd1};
        t3_pls  = '{128'h10, 128'h11, 128'h13, 128'h21};
        for (int k = 0; k < 4; k++) begin
            set_msg(t3_tags[k], t3_pls[k]);
            pipe_enq_ena = 1'b1;
            #1;
            check("t3_rdy", pipe_enq_rdy, 1'b1);
            step();
        end
        pipe_enq_ena = 1'b0;
        set_msg(16'd0, '0);
        check("t3_last_ena", method_ena, 4'b0010);
        check("t3_last_v1", method_v[255:128], 128'h21);
        repeat (2) step();

        // Bad tags are dropped and counted; clear wins over a same-cycle drop
        set_msg(16'd7, 128'hA);
        pipe_enq_ena = 1'b1;
        step();
        set_msg(16'hFFFF, 128'hB);
        step();
        pipe_enq_ena = 1'b0;
        set_msg(16'd0, '0);
        check("t4_drop2", drop_count, 4'd2);
        check("t4_bad", last_bad_tag, 16'hFFFF);
        check("t4_no_ena", method_ena, 4'b0000);
        set_msg(16'd9, 128'hC);
        pipe_enq_ena = 1'b1;
        clear_stats  = 1'b1;
        step();
        pipe_enq_ena = 1'b0;
        clear_stats  = 1'b0;
        set_msg(16'd0, '0);
        check("t4_clr_drop", drop_count, 4'd0);
        check("t4_clr_bad", last_bad_tag, 16'h0000);

        // Saturation at 4'hF after 17 drops
        for (int k = 0; k < 17; k++) begin
            set_msg(16'h0100 + 16'(k), DW'(k));
            pipe_enq_ena = 1'b1;
            step();
        end
        pipe_enq_ena = 1'b0;
        set_msg(16'd0, '0);
        check("t5_sat", drop_count, 4'hF);
        check("t5_bad", last_bad_tag, 16'h0110);

        // Asynchronous reset with channel 1 holding two entries
        method_rdy = 4'b1101;
        set_msg(16'd1, 128'hA1);
        pipe_enq_ena = 1'b1;
        step();
        set_msg(16'd1, 128'hA2);
        step();
        pipe_enq_ena = 1'b0;
        set_msg(16'd1, 128'hA3);
        #1;
        check("t6_full", pipe_enq_rdy, 1'b0);
        method_rdy = 4'hF;
        #1;
        check("t6_pre_ena", method_ena, 4'b0010);
        #1;
        nRST = 1'b0;
        #1;
        check("t6_async_ena", method_ena, 4'b0000);
        check("t6_async_v", |method_v, 1'b0);
        check("t6_async_drop", drop_count, 4'h0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        check("t6_rel_rdy", pipe_enq_rdy, 1'b1);
        check("t6_rel_ena", method_ena, 4'b0000);
        repeat (3) step();
        check("t6_no_stale", method_ena, 4'b0000);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p2m_demux.md
Name: p2m_demux

Overview:
- Parametrised pipe-to-method demultiplexer. Accepts tagged messages on one PipeIn-style enq port.
- Routes each message by its tag field to one of NUM_METHODS method-call ports, each with its own small FIFO. The FIFOs decouple a stalled method from the others.
- Messages with an out-of-range tag are accepted and dropped, and counted.
- Successor to the single-method, unbuffered pipe-to-method adapters; sits between the pipe transport and the generated method clients.

Parameters:
- TAG_WIDTH, 16, width of tag field in enq message (MSBs).
- DATA_WIDTH, 128, payload width (LSBs); forwarded unmodified to method.
- NUM_METHODS, 4, number of method ports; tags 0..NUM_METHODS-1 valid, 1..16.
- FIFO_DEPTH, 2, entries per channel FIFO; power of two, ≥2.
- CNT_WIDTH, 32, width of drop counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous assert, active-low.
- pipe_enq_v  in  TAG_WIDTH+DATA_WIDTH  message; tag = [TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH], payload = [DATA_WIDTH-1:0].
- pipe_enq_ena  in  1  enq fires; asserted only when pipe_enq_rdy=1.
- pipe_enq_rdy  out  1  enq may fire this cycle.
- method_v  out  NUM_METHODS*DATA_WIDTH  payload for method i at slice i.
- method_ena  out  NUM_METHODS  method i call fires.
- method_rdy  in  NUM_METHODS  method i can accept.
- drop_count  out  CNT_WIDTH  saturating count of dropped messages.
- last_bad_tag  out  TAG_WIDTH  tag of most recent dropped message.
- clear_stats  in  1  sync clear of drop_count and last_bad_tag.

Behaviour:
- Reset (nRST=0, asynchronous): all FIFOs empty, pointers 0, drop_count=0, last_bad_tag=0. method_ena=0 and method_v=0 while nRST=0. Any message in flight is lost, and no partial state remains after release.
- Decode is combinational from pipe_enq_v: valid = (tag < NUM_METHODS); ch = tag[clog2(NUM_METHODS)-1:0].
- pipe_enq_rdy = valid ? !full[ch] : 1.
  - Depends on pipe_enq_v only, never on method_rdy. There is no rdy-to-rdy combinational path.
  - No push into a full FIFO, even if that FIFO pops in the same cycle.
- pipe_enq_ena & valid: the payload is written at the wr_ptr of FIFO ch on the rising CLK edge.
- pipe_enq_ena & !valid: the message is discarded. drop_count += 1, saturating at all-ones. last_bad_tag <= tag.
- clear_stats=1 takes priority over a same-cycle increment: drop_count <= 0 and last_bad_tag <= 0, and that drop is not counted.
- Per-channel FIFO i:
  - method_v[i] = head entry when non-empty, else 0.
  - method_ena[i] = !empty[i] & method_rdy[i]. Pop on method_ena[i].
- Latency: enq to earliest method_ena is 1 cycle (registered, no bypass).
  - Sustained throughput is 1 message/cycle per channel when method_rdy stays high.
  - FIFO_DEPTH=2 gives full rate.
- Occupancy uses ptr width clog2(FIFO_DEPTH)+1. Pointers wrap modulo 2*FIFO_DEPTH. full = MSBs differ & LSBs equal.
- Push and pop on the same non-full, non-empty FIFO in one cycle: occupancy unchanged, order preserved.
- Ordering: strict FIFO per channel. There is no ordering guarantee across channels.
- Channels are independent. A channel with method_rdy=0 blocks enq only while the head message targets that full channel. This is head-of-line blocking on the input, which is accepted.

Decomposition:
- Package p2m_pkg holds:
  - clog2-derived widths (CH_W, PTR_W);
  - a message struct typedef {tag, payload} parameterised via localparams;
  - the function tag_valid().
- One sub-module p2m_chan_fifo (parameters DATA_WIDTH, FIFO_DEPTH; ports push/din/full, pop/dout/empty), instantiated NUM_METHODS times in a generate loop.
- Top holds decode, drop stats and the output mux.

Test Plan:
- Reset, then one enq tag=0 payload=0x...DEADBEEF with method_rdy=4'hF: method_ena[0]=1 exactly one cycle later, method_v[0]=payload, other ena=0.
- method_rdy[2]=0, enq 3 messages tag=2: first two accepted. pipe_enq_rdy=0 for the third. Raise method_rdy[2]: pops in order 1,2, then the third is accepted.
- Interleaved tags 0,1,3,1 back-to-back with all rdy=1: each channel receives its messages in order, and pipe_enq_rdy stays 1 throughout.
- enq tag=7 then tag=16'hFFFF with NUM_METHODS=4: both accepted, no method_ena, drop_count=2, last_bad_tag=16'hFFFF. A clear_stats pulse coincident with a third bad tag leaves drop_count=0.
- Set drop_count near saturation (CNT_WIDTH=4, 17 bad tags): drop_count holds 4'hF.
- Assert nRST low mid-stream with FIFO 1 holding 2 entries: method_ena goes 0 asynchronously. After release, no stale entries pop and pipe_enq_rdy=1.
